// File: rtl/pmu_i2c_seq.sv
// pmu_i2c_seq: register-write command sequencer for the PMU I2C byte engine.
//
// Buffers {addr, reg, val} commands in a DEPTH-entry FIFO. Each command is
// sent as one 3-byte write (addr+W, reg, val). A NAKed attempt is retried
// after RETRY_GAP idle cycles, up to MAX_RETRY attempts in total. The
// outcome of each command is reported with one pulse: tx_ok or tx_err.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   cmd_valid/cmd_ready   command push handshake (cmd_ready = FIFO not full)
//   cmd_addr/reg/val      7-bit slave address, register, value
//   busy                  FIFO non-empty or a transaction in flight
//   tx_ok / tx_err        one-cycle completion / failure pulse for the head
//   err_addr / err_reg    fields of the most recent failed command
//   i2c_data              byte offered to the engine (addr+W, reg, val)
//   i2c_start             request a transaction (one cycle)
//   i2c_done              the value byte has been latched (last byte)
//   i2c_rw                always 1 (write)
//   i2c_data_latch        engine captured i2c_data this cycle
//   i2c_ready             engine idle
//   i2c_failed            engine saw a NAK (sticky)
//   i2c_clear_failed      one-cycle pulse clearing the engine NAK flag
module pmu_i2c_seq #(
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 3,
    parameter int RETRY_GAP = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_val,
    output logic       busy,
    output logic       tx_ok,
    output logic       tx_err,
    output logic [6:0] err_addr,
    output logic [7:0] err_reg,
    output logic [7:0] i2c_data,
    output logic       i2c_start,
    output logic       i2c_done,
    output logic       i2c_rw,
    input  logic       i2c_data_latch,
    input  logic       i2c_ready,
    input  logic       i2c_failed,
    output logic       i2c_clear_failed
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE, LAUNCH, WAIT_BUSY, WAIT_IDLE, CHECK, GAP
    } state_t;

    // ---------------- command FIFO ----------------
    logic [22:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full, empty, push, pop;
    logic [22:0]      head;

    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    assign cmd_ready = ~full;
    assign push      = cmd_valid & ~full;
    // The head is read combinationally so i2c_data follows byte_cnt directly.
    assign head      = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {cmd_addr, cmd_reg, cmd_val};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ---------------- sequencer ----------------
    state_t      state_reg, state_next;
    logic [3:0]  attempt_reg, attempt_next;
    logic [7:0]  gap_cnt_reg;
    logic [1:0]  wait_cnt_reg;
    logic [1:0]  byte_cnt_reg;
    logic        err_capture;

    always_comb begin
        state_next       = state_reg;
        attempt_next     = attempt_reg;
        pop              = 1'b0;
        tx_ok            = 1'b0;
        tx_err           = 1'b0;
        i2c_start        = 1'b0;
        i2c_clear_failed = 1'b0;
        err_capture      = 1'b0;
        case (state_reg)
            IDLE: begin
                attempt_next = '0;
                if (!empty && i2c_ready) state_next = LAUNCH;
            end
            LAUNCH: begin
                i2c_start  = 1'b1;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Engine never acknowledged the start: relaunch without
                // charging an attempt.
                if (!i2c_ready)                state_next = WAIT_IDLE;
                else if (wait_cnt_reg == 2'd3) state_next = LAUNCH;
            end
            WAIT_IDLE: begin
                if (i2c_ready) state_next = CHECK;
            end
            CHECK: begin
                // Success needs all three bytes latched and no NAK; an
                // early engine stop leaves byte_cnt short and is a failure.
                if (!i2c_failed && byte_cnt_reg == 2'd3) begin
                    tx_ok      = 1'b1;
                    pop        = 1'b1;
                    state_next = IDLE;
                end else begin
                    i2c_clear_failed = 1'b1;
                    attempt_next     = attempt_reg + 4'd1;
                    if (attempt_reg + 4'd1 == 4'(MAX_RETRY)) begin
                        tx_err      = 1'b1;
                        pop         = 1'b1;
                        err_capture = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_reg == 8'(RETRY_GAP - 1)) state_next = LAUNCH;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            attempt_reg  <= '0;
            gap_cnt_reg  <= '0;
            wait_cnt_reg <= '0;
            byte_cnt_reg <= '0;
            err_addr     <= '0;
            err_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            attempt_reg <= attempt_next;
            gap_cnt_reg  <= (state_reg == GAP) ? gap_cnt_reg + 8'd1 : 8'd0;
            wait_cnt_reg <= (state_reg == WAIT_BUSY) ? wait_cnt_reg + 2'd1 : 2'd0;
            // Every launch (first attempt, retry or relaunch) restarts at the
            // address byte.
            if (state_next == LAUNCH) begin
                byte_cnt_reg <= '0;
            end else if (i2c_data_latch && byte_cnt_reg != 2'd3) begin
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
            end
            if (err_capture) begin
                err_addr <= head[22:16];
                err_reg  <= head[15:8];
            end
        end
    end

    always_comb begin
        case (byte_cnt_reg)
            2'd0:    i2c_data = {head[22:16], 1'b0};
            2'd1:    i2c_data = head[15:8];
            default: i2c_data = head[7:0];
        endcase
    end

    assign i2c_done = (byte_cnt_reg == 2'd3);
    assign i2c_rw   = 1'b1;
    assign busy     = !empty || (state_reg != IDLE);

endmodule

// File: tb/tb_pmu_i2c_seq.sv
// Testbench for pmu_i2c_seq: a behavioural I2C byte engine with per-attempt
// NAK plans, a scoreboard of expected outcomes filled at push time, and a
// monitor that pops and compares on every tx_ok/tx_err pulse.
module tb_pmu_i2c_seq;
    localparam int DEPTH     = 4;
    localparam int MAX_RETRY = 3;
    localparam int RETRY_GAP = 16;

    logic       clk, reset;
    logic       cmd_valid, cmd_ready;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_reg, cmd_val;
    logic       busy, tx_ok, tx_err;
    logic [6:0] err_addr;
    logic [7:0] err_reg;
    logic [7:0] i2c_data;
    logic       i2c_start, i2c_done, i2c_rw;
    logic       i2c_data_latch, i2c_ready, i2c_failed, i2c_clear_failed;

    pmu_i2c_seq #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_reg(cmd_reg), .cmd_val(cmd_val),
        .busy(busy), .tx_ok(tx_ok), .tx_err(tx_err),
        .err_addr(err_addr), .err_reg(err_reg),
        .i2c_data(i2c_data), .i2c_start(i2c_start), .i2c_done(i2c_done), .i2c_rw(i2c_rw),
        .i2c_data_latch(i2c_data_latch), .i2c_ready(i2c_ready),
        .i2c_failed(i2c_failed), .i2c_clear_failed(i2c_clear_failed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // nak holds one 2-bit code per attempt: 0/1/2 = byte NAKed, 3 = all ACKed.
    typedef struct packed {
        logic [6:0]  addr;
        logic [7:0]  rg;
        logic [7:0]  val;
        logic [29:0] nak;
    } cmd_t;
    typedef struct packed {
        logic       ok;
        logic [4:0] attempts;
    } exp_t;

    localparam logic [29:0] ALL_ACK = 30'h3FFF_FFFF;

    cmd_t       cmd_q[$];
    exp_t       exp_q[$];
    logic [7:0] obs_bytes[$];
    int n_cmp = 0, n_fail = 0, n_txn = 0;
    int cyc = 0, obs_starts = 0, obs_clears = 0, last_clear_cyc = 0;
    logic       stall = 1'b0;
    logic       err_pending = 1'b0;
    logic [6:0] err_addr_exp;
    logic [7:0] err_reg_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference outcome: the first attempt whose plan is all-ACK succeeds;
    // none within MAX_RETRY means failure after MAX_RETRY attempts.
    function automatic exp_t model(input cmd_t c);
        exp_t e;
        e.ok = 1'b0;
        e.attempts = 5'(MAX_RETRY);
        for (int a = MAX_RETRY - 1; a >= 0; a--) begin
            if (c.nak[2*a +: 2] == 2'd3) begin
                e.ok = 1'b1;
                e.attempts = 5'(a + 1);
            end
        end
        return e;
    endfunction

    function automatic cmd_t mk(input logic [6:0] a, input logic [7:0] r,
                                input logic [7:0] v, input logic [29:0] n);
        cmd_t c;
        c.addr = a; c.rg = r; c.val = v; c.nak = n;
        return c;
    endfunction

    function automatic logic [29:0] rand_plan();
        logic [29:0] n;
        int r;
        n = '0;
        for (int a = 0; a < 15; a++) begin
            r = int'($urandom_range(0, 9));
            n[2*a +: 2] = (r < 6) ? 2'd3 : 2'(r - 6);
        end
        return n;
    endfunction

    // ---------------- engine model ----------------
    int         e_busy = 0, e_byte = 0, e_ph = 0;
    logic       s_start, s_clear, s_done;
    logic [7:0] s_data;

    function automatic logic nak_here();
        cmd_t c;
        int   att;
        logic [29:0] n;
        if (cmd_q.size() == 0) return 1'b0;
        c = cmd_q[0];
        n = c.nak;
        att = obs_starts - 1;
        if (att < 0 || att > 14) return 1'b0;
        return (n[2*att +: 2] == 2'(e_byte));
    endfunction

    initial begin
        i2c_ready = 1'b1; i2c_data_latch = 1'b0; i2c_failed = 1'b0;
        forever begin
            @(negedge clk);
            s_start = i2c_start; s_clear = i2c_clear_failed;
            s_done = i2c_done; s_data = i2c_data;
            @(posedge clk);
            #1;
            if (reset) begin
                e_busy = 0; i2c_ready = 1'b1; i2c_data_latch = 1'b0; i2c_failed = 1'b0;
            end else begin
                if (s_clear) i2c_failed = 1'b0;
                if (e_busy == 0) begin
                    if (s_start && !stall) begin
                        e_busy = 1; e_byte = 0; e_ph = 0; i2c_ready = 1'b0;
                    end else begin
                        i2c_ready = !stall;
                    end
                end else begin
                    case (e_ph)
                        0: begin i2c_data_latch = 1'b1; e_ph = 1; end
                        1: begin i2c_data_latch = 1'b0; obs_bytes.push_back(s_data); e_ph = 2; end
                        default: begin
                            check("i2c_done_at_ack", 32'(s_done), 32'(e_byte == 2));
                            if (nak_here()) begin
                                i2c_failed = 1'b1; i2c_ready = 1'b1; e_busy = 0;
                            end else if (s_done || e_byte == 2) begin
                                i2c_ready = 1'b1; e_busy = 0;
                            end else begin
                                e_byte++; e_ph = 0;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t       e;
        cmd_t       c;
        logic       ok_b;
        int         idx, nb;
        logic [1:0] code;
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (err_pending) begin
                    check("err_addr", 32'(err_addr), 32'(err_addr_exp));
                    check("err_reg", 32'(err_reg), 32'(err_reg_exp));
                    err_pending = 1'b0;
                end
                if (i2c_start) begin
                    if (obs_clears > 0)
                        check("retry_gap_ok", 32'((cyc - last_clear_cyc) >= RETRY_GAP + 1), 32'd1);
                    obs_starts++;
                end
                if (i2c_clear_failed) begin
                    obs_clears++;
                    last_clear_cyc = cyc;
                end
                if (tx_ok && tx_err) check("ok_err_exclusive", 32'(tx_ok & tx_err), 32'd0);
                if (tx_ok || tx_err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 32'(tx_ok | tx_err), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        c = cmd_q.pop_front();
                        check("completion_kind", 32'(tx_ok), 32'(e.ok));
                        check("start_count", 32'(obs_starts), 32'(e.attempts));
                        check("clear_count", 32'(obs_clears), 32'(e.attempts) - 32'(e.ok));
                        ok_b = 1'b1;
                        idx = 0;
                        for (int a = 0; a < int'(e.attempts); a++) begin
                            code = c.nak[2*a +: 2];
                            nb = (code == 2'd3) ? 3 : int'(code) + 1;
                            for (int j = 0; j < nb; j++) begin
                                exp_b = (j == 0) ? {c.addr, 1'b0} : (j == 1) ? c.rg : c.val;
                                if (idx >= obs_bytes.size()) ok_b = 1'b0;
                                else if (obs_bytes[idx] !== exp_b) ok_b = 1'b0;
                                idx++;
                            end
                        end
                        if (idx != obs_bytes.size()) ok_b = 1'b0;
                        check("byte_stream", 32'(ok_b), 32'd1);
                        if (tx_err) begin
                            err_pending = 1'b1;
                            err_addr_exp = c.addr;
                            err_reg_exp = c.rg;
                        end
                        $display("txn %0d: addr=0x%02h reg=0x%02h val=0x%02h %s attempts=%0d bytes=%0d",
                                 n_txn, c.addr, c.rg, c.val, tx_ok ? "ok" : "err",
                                 obs_starts, obs_bytes.size());
                        n_txn++;
                        obs_starts = 0; obs_clears = 0;
                        obs_bytes.delete();
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push(input cmd_t c);
        int t;
        t = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = c.addr; cmd_reg = c.rg; cmd_val = c.val;
        while (!cmd_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            check("push_accepted", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
        end else begin
            exp_q.push_back(model(c));
            cmd_q.push_back(c);
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("busy_after_drain", 32'(busy), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int t;
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_reg = '0; cmd_val = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_ok", 32'(tx_ok), 32'd0);
        check("rst_tx_err", 32'(tx_err), 32'd0);
        check("rst_err_addr", 32'(err_addr), 32'd0);
        check("rst_err_reg", 32'(err_reg), 32'd0);
        check("rst_i2c_start", 32'(i2c_start), 32'd0);
        check("rst_i2c_done", 32'(i2c_done), 32'd0);
        check("rst_clear_failed", 32'(i2c_clear_failed), 32'd0);
        check("i2c_rw", 32'(i2c_rw), 32'd1);
        reset = 1'b0;

        // Single all-ACK command.
        push(mk(7'h48, 8'h10, 8'hA5, ALL_ACK));
        wait_drain();

        // Five back-to-back with the engine stalled: FIFO fills at four.
        stall = 1'b1;
        for (int i = 0; i < 4; i++) push(mk(7'(8'h20 + i), 8'(i), 8'(8'hC0 + i), ALL_ACK));
        @(negedge clk);
        check("cmd_ready_when_full", 32'(cmd_ready), 32'd0);
        check("busy_when_full", 32'(busy), 32'd1);
        stall = 1'b0;
        push(mk(7'h24, 8'h04, 8'hC4, ALL_ACK));
        wait_drain();

        // Address NAK on every attempt, then a good command.
        push(mk(7'h48, 8'h10, 8'h77, 30'h0));
        push(mk(7'h33, 8'h44, 8'h55, ALL_ACK));
        wait_drain();

        // Value-byte NAK on the first attempt only.
        push(mk(7'h51, 8'h22, 8'h99, {ALL_ACK[29:2], 2'd2}));
        wait_drain();

        // Randomised commands and NAK plans with random spacing.
        for (int i = 0; i < 40; i++) begin
            push(mk(7'($urandom), 8'($urandom), 8'($urandom), rand_plan()));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain();

        // Reset mid-transaction with commands queued.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) push(mk(7'(8'h60 + i), 8'(8'h70 + i), 8'(8'h80 + i), ALL_ACK));
        stall = 1'b0;
        t = 0;
        while (!(e_busy == 1 && e_ph == 1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("reached_wait_idle", 32'(e_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_i2c_start", 32'(i2c_start), 32'd0);
        check("mid_rst_tx_ok", 32'(tx_ok), 32'd0);
        check("mid_rst_tx_err", 32'(tx_err), 32'd0);
        exp_q.delete(); cmd_q.delete(); obs_bytes.delete();
        obs_starts = 0; obs_clears = 0; err_pending = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        push(mk(7'h48, 8'h10, 8'hA5, ALL_ACK));
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
